// File: rtl/stv_pkg.sv
// rtl/stv_pkg.sv - shared helpers for stv link blocks
// clog2p1(n) gives the width needed to hold values 0..n inclusive.
package stv_pkg;

  function automatic int clog2p1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/stv_sat_updown_cnt.sv
// rtl/stv_sat_updown_cnt.sv - saturating up/down counter clamped to 0..MAX
// ovf flags an increment that was absorbed by saturation at MAX.
module stv_sat_updown_cnt
  import stv_pkg::*;
#(
  parameter int MAX       = 8,
  parameter int RESET_VAL = MAX,
  localparam int W        = clog2p1(MAX)
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         ovf
);

  localparam int W1 = W + 1;

  logic [W-1:0] count_q, count_d;
  logic [W:0]   sum;
  logic         underflow;

  assign underflow = dec && !inc && (count_q == '0);
  assign ovf       = !clear && inc && !dec && (count_q == W'(MAX));

  // One extra bit so an increment past MAX is visible before clamping
  always_comb begin
    sum = {1'b0, count_q} + W1'(inc) - W1'(dec);
    if (clear)                 count_d = W'(RESET_VAL);
    else if (underflow)        count_d = count_q;
    else if (sum > W1'(MAX))   count_d = W'(MAX);
    else                       count_d = sum[W-1:0];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) count_q <= W'(RESET_VAL);
    else         count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/stv_credit_tx.sv
// rtl/stv_credit_tx.sv - credit-based transmitter toward a remote FIFO with no ready wire
// Define STV_CREDIT_TX_OVF_CHECK_EN to build the sticky credit-overflow flag.
module stv_credit_tx
  import stv_pkg::*;
#(
  parameter type data_t   = logic [7:0],
  parameter int  CREDITS  = 8,
  parameter bit  OUT_REG  = 1'b1,
  localparam int CNTWIDTH = clog2p1(CREDITS)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                clear,
  input  logic                din_valid,
  output logic                din_ready,
  input  data_t               din,
  output logic                dout_valid,
  output data_t               dout,
  input  logic                credit_return,
  output logic [CNTWIDTH-1:0] credits,
  output logic                idle,
  output logic                overflow
);

  logic send;
  logic cnt_ovf;

  // Ready looks only at the registered count, never at credit_return
  assign din_ready = (credits != '0) && !clear;
  assign send      = din_valid && din_ready;

  stv_sat_updown_cnt #(
    .MAX       (CREDITS),
    .RESET_VAL (CREDITS)
  ) u_credit_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (credit_return),
    .dec    (send),
    .clear  (clear),
    .count  (credits),
    .ovf    (cnt_ovf)
  );

  generate
    if (OUT_REG) begin : g_out_reg
      logic  valid_q;
      data_t data_q;

      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) valid_q <= 1'b0;
        else         valid_q <= send;
      end

      always_ff @(posedge clk) begin
        if (send) data_q <= din;
      end

      assign dout_valid = valid_q;
      assign dout       = data_q;
    end else begin : g_out_comb
      assign dout_valid = send;
      assign dout       = din;
    end
  endgenerate

  assign idle = (credits == CNTWIDTH'(CREDITS)) && !dout_valid;

`ifdef STV_CREDIT_TX_OVF_CHECK_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)      ovf_q <= 1'b0;
    else if (clear)   ovf_q <= 1'b0;
    else if (cnt_ovf) ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;

`ifdef STV_ASSERT_ON
  always_ff @(posedge clk) begin
    if (arst_n) assert (!cnt_ovf) else $error("stv_credit_tx: credit returned with all credits home");
  end
`endif
`else
  logic unused_ovf;
  assign unused_ovf = cnt_ovf;
  assign overflow   = 1'b0;
`endif

`ifdef STV_ASSERT_ON
  logic  hold_q;
  data_t din_hold_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hold_q <= 1'b0;
    end else begin
      hold_q     <= din_valid && !din_ready;
      din_hold_q <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (arst_n && hold_q) assert (din_valid && (din == din_hold_q))
      else $error("stv_credit_tx: din dropped or changed before acceptance");
  end
`endif

endmodule
